// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Resolves mem-wait, multi-cycle EX, taken-branch and load-use hazards; counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             id_ex_mem_read_i,
  input  logic [REG_W-1:0] id_ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_mc_start_i,
  input  logic             mem_busy_i,
  input  logic             stall_cnt_clr_i,
  output logic             pc_lock_o,
  output logic             if_id_lock_o,
  output logic             if_id_flush_o,
  output logic             id_ex_lock_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_lock_o,
  output logic             ex_mem_flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int CD_W = (MC_CYCLES > 2) ? $clog2(MC_CYCLES - 1) : 1;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  state_t            state_q;
  logic [CD_W-1:0]   cd_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              load_use;
  logic              mc_hold;

  assign load_use = id_ex_mem_read_i && (id_ex_rd_i != '0) &&
                    (((id_ex_rd_i == id_rs1_i) && id_rs1_used_i) ||
                     ((id_ex_rd_i == id_rs2_i) && id_rs2_used_i));

  // The start cycle already counts as the first of the MC_CYCLES stall cycles.
  assign mc_hold = (state_q == ST_MC_BUSY) || ex_mc_start_i;

  always_comb begin
    pc_lock_o      = 1'b0;
    if_id_lock_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_lock_o   = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_lock_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (rst_i) begin
      pc_lock_o = 1'b0;
    end else if (mem_busy_i) begin
      pc_lock_o     = 1'b1;
      if_id_lock_o  = 1'b1;
      id_ex_lock_o  = 1'b1;
      ex_mem_lock_o = 1'b1;
    end else if (mc_hold) begin
      pc_lock_o      = 1'b1;
      if_id_lock_o   = 1'b1;
      id_ex_lock_o   = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_lock_o     = 1'b1;
      if_id_lock_o  = 1'b1;
      id_ex_flush_o = 1'b1;
    end
  end

  assign busy_o      = !rst_i && (state_q == ST_MC_BUSY);
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cd_q    <= '0;
    end else if (!mem_busy_i) begin
      case (state_q)
        ST_RUN: begin
          if (ex_mc_start_i) begin
            state_q <= ST_MC_BUSY;
            cd_q    <= CD_W'(MC_CYCLES - 2);
          end
        end
        ST_MC_BUSY: begin
          if (cd_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            cd_q <= cd_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cd_q    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_clr_i) begin
      stall_cnt_q <= '0;
    end else if (pc_lock_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
// Driver pushes hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_ex_rd_i = '0;
  logic       id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0, id_ex_mem_read_i = 1'b0;
  logic       ex_branch_taken_i = 1'b0, ex_mc_start_i = 1'b0, mem_busy_i = 1'b0;
  logic       stall_cnt_clr_i = 1'b0;
  logic       pc_lock_o, if_id_lock_o, if_id_flush_o, id_ex_lock_o, id_ex_flush_o;
  logic       ex_mem_lock_o, ex_mem_flush_o, busy_o;
  logic [3:0] stall_cnt_o;
  logic [7:0] obs;

  // Output vector order: {pc_lock, if_id_lock, if_id_flush, id_ex_lock, id_ex_flush, ex_mem_lock, ex_mem_flush, busy}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_1000;
  localparam logic [7:0] O_BR   = 8'b0010_1000;
  localparam logic [7:0] O_MCS  = 8'b1101_0010;
  localparam logic [7:0] O_MCB  = 8'b1101_0011;
  localparam logic [7:0] O_MB   = 8'b1101_0100;
  localparam logic [7:0] O_MBB  = 8'b1101_0101;

  typedef struct {
    logic [7:0] o;
    logic [3:0] c;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  pipeline_hazard_ctrl #(.REG_W(5), .MC_CYCLES(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_ex_mem_read_i(id_ex_mem_read_i), .id_ex_rd_i(id_ex_rd_i),
    .ex_branch_taken_i(ex_branch_taken_i), .ex_mc_start_i(ex_mc_start_i),
    .mem_busy_i(mem_busy_i), .stall_cnt_clr_i(stall_cnt_clr_i),
    .pc_lock_o(pc_lock_o), .if_id_lock_o(if_id_lock_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_lock_o(id_ex_lock_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_lock_o(ex_mem_lock_o), .ex_mem_flush_o(ex_mem_flush_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  assign obs = {pc_lock_o, if_id_lock_o, if_id_flush_o, id_ex_lock_o, id_ex_flush_o,
                ex_mem_lock_o, ex_mem_flush_o, busy_o};

  always #5 clk_i = ~clk_i;

  task automatic step(input logic r, input logic mb, input logic mc, input logic br,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic clr, input logic [7:0] eo, input int ec, input string nm);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = r; mem_busy_i = mb; ex_mc_start_i = mc; ex_branch_taken_i = br;
    id_ex_mem_read_i = mr; id_ex_rd_i = rd; id_rs1_i = rs1; id_rs1_used_i = u1;
    id_rs2_i = rs2; id_rs2_used_i = u2; stall_cnt_clr_i = clr;
    e.o = eo; e.c = 4'(ec); e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int ec, input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, ec, nm);
  endtask

  task automatic lu(input logic clr, input int ec, input string nm);
    step(0, 0, 0, 0, 1, 5, 5, 1, 0, 0, clr, O_LU, ec, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (obs === e.o) passed++;
        else $display("FAIL %s outputs: got %b expected %b", e.nm, obs, e.o);
        total++;
        if (stall_cnt_o === e.c) passed++;
        else $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, stall_cnt_o, e.c);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int wait_cyc;
    // Reset: outputs zero even with mem_busy asserted
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0, "reset_membusy");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0, "reset");
    idle(0, "idle_after_reset");

    // Load-use via rs1, then rd=0, rs2 match, rs2 unused
    lu(0, 0, "lu_rs1");
    idle(1, "lu_released");
    step(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, O_NONE, 1, "lu_rd_zero");
    step(0, 0, 0, 0, 1, 7, 0, 0, 7, 1, 0, O_LU, 1, "lu_rs2");
    step(0, 0, 0, 0, 1, 7, 0, 0, 7, 0, 0, O_NONE, 2, "lu_rs2_unused");

    // Branch overrides a concurrent load-use
    step(0, 0, 0, 1, 1, 5, 5, 1, 0, 0, 0, O_BR, 2, "branch_over_lu");
    idle(2, "after_branch");

    // Multi-cycle op: 4 stall cycles, branch/load-use ignored while busy
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 2, "clr_a");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_MCS, 0, "mc_start");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MCB, 1, "mc_busy2");
    step(0, 0, 0, 1, 1, 5, 5, 1, 0, 0, 0, O_MCB, 2, "mc_busy3_br_lu");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MCB, 3, "mc_busy4");
    idle(4, "mc_done");

    // mem_busy freezes MC_BUSY at countdown 1: 7 stall cycles total
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 4, "clr_b");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_MCS, 0, "mc2_start");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MCB, 1, "mc2_busy_cd2");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MBB, 2, "mc2_mem1");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MBB, 3, "mc2_mem2");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MBB, 4, "mc2_mem3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MCB, 5, "mc2_resume_cd1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MCB, 6, "mc2_resume_cd0");
    idle(7, "mc2_done");

    // mem_busy suppresses a held branch until it releases
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_MB, 7, "mem_br1");
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_MB, 8, "mem_br2");
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_BR, 9, "br_after_mem");
    idle(9, "after_mem_br");

    // Saturation at 15 and clear priority over a concurrent stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE, 9, "clr_c");
    for (int i = 0; i < 20; i++) lu(0, (i > 15) ? 15 : i, "sat_ramp");
    lu(1, 15, "sat_clr_with_stall");
    idle(0, "after_clr");

    // Reset asserted in MC_BUSY
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_MCS, 0, "mc3_start");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MCB, 1, "mc3_busy");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0, "reset_mid_mc");
    idle(0, "run_after_reset");

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk_i);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage segmented pipeline. It detects load-use hazards, taken branches, multi-cycle EX operations and data-memory wait states. It drives the lock/flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM latches. A small FSM holds the pipeline for multi-cycle operations, and a saturating counter records stall cycles for performance measurement.

Parameters:
REG_W, 5, register-index width
MC_CYCLES, 4, total stall cycles for a multi-cycle EX op (>= 2)
CNT_W, 16, stall performance counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
id_rs1_i  in  REG_W  rs1 index of the instruction in ID
id_rs2_i  in  REG_W  rs2 index of the instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
id_ex_mem_read_i  in  1  instruction in EX is a load
id_ex_rd_i  in  REG_W  destination register of the instruction in EX
ex_branch_taken_i  in  1  EX resolved a taken branch or jump
ex_mc_start_i  in  1  multi-cycle op entered EX this cycle (1-cycle pulse)
mem_busy_i  in  1  data memory not ready; hold everything
stall_cnt_clr_i  in  1  synchronous clear of the stall counter
pc_lock_o  out  1  hold PC
if_id_lock_o  out  1  hold IF/ID latch
if_id_flush_o  out  1  zero IF/ID latch
id_ex_lock_o  out  1  hold ID/EX latch
id_ex_flush_o  out  1  zero ID/EX latch (bubble)
ex_mem_lock_o  out  1  hold EX/MEM latch
ex_mem_flush_o  out  1  zero EX/MEM latch (bubble)
busy_o  out  1  FSM not in RUN
stall_cnt_o  out  CNT_W  saturating count of cycles with pc_lock_o=1

Behaviour:
- Outputs are combinational from registered state and the current inputs, so they take effect at the same clock edge. Only the FSM state, the MC countdown and stall_cnt are registered.
- While rst_i=1, all outputs are 0. The FSM is in RUN, the countdown is 0 and stall_cnt is 0.
- FSM states are RUN and MC_BUSY. Priority order: mem_busy > multi-cycle > branch > load-use.
- mem_busy_i=1, any state:
  - pc_lock, if_id_lock, id_ex_lock and ex_mem_lock are all 1; every flush output is 0.
  - FSM state and countdown are frozen.
  - Branch and load-use conditions are suppressed. The branch is re-evaluated once the stall releases, because EX is held.
- RUN with ex_mc_start_i=1:
  - pc_lock, if_id_lock and id_ex_lock are 1, and ex_mem_flush is 1.
  - Next state is MC_BUSY with countdown = MC_CYCLES-2.
  - A simultaneous ex_branch_taken_i is ignored; it is a protocol violation.
- MC_BUSY: drives the same outputs as the start cycle.
  - If countdown = 0, next state is RUN; otherwise the countdown decrements.
  - Total stall = exactly MC_CYCLES cycles, including the start cycle.
  - ex_branch_taken_i and load-use are ignored in this state.
- RUN with ex_branch_taken_i=1: if_id_flush and id_ex_flush are 1, with no locks. The PC loads the target.
  - The branch overrides load-use, because the dependent instruction is being squashed.
- RUN with load-use: condition is id_ex_mem_read_i & id_ex_rd_i!=0 & ((rd==rs1 & rs1_used) | (rd==rs2 & rs2_used)).
  - Response: pc_lock=1, if_id_lock=1, id_ex_flush=1, for exactly one cycle.
  - No FSM state change; the load advances, which clears the condition.
- Lock and flush are never both asserted on the same latch.
- stall_cnt:
  - Increments on each edge where pc_lock_o=1, saturating at 2^CNT_W-1.
  - stall_cnt_clr_i=1 forces 0 and takes priority over increment.
- busy_o = (state==MC_BUSY).
- Reset asserted mid-MC_BUSY: immediate return to RUN, and all outputs are 0 asynchronously.

Test Plan:
1. Load-use: mem_read=1, rd=5, rs1=5, rs1_used=1 -> one cycle of pc_lock=if_id_lock=id_ex_flush=1; stall_cnt goes 0->1. Repeat with rd=0 -> no stall.
2. Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use match -> if_id_flush=id_ex_flush=1, pc_lock=0, stall_cnt unchanged.
3. Multi-cycle op, MC_CYCLES=4: ex_mc_start pulse -> pc_lock, id_ex_lock and ex_mem_flush high for exactly 4 cycles; busy_o high for cycles 2-4; stall_cnt=4 afterwards.
4. mem_busy for 3 cycles during MC_BUSY at countdown 1 -> all four locks high and no flushes for 3 cycles; MC stall then resumes for the remaining 2 cycles; total stall = 7.
5. mem_busy with ex_branch_taken held -> no flush during busy; flush asserted in the first cycle after mem_busy falls.
6. Saturation and clear, CNT_W=4: 20 stall cycles -> stall_cnt=15; stall_cnt_clr with a concurrent stall -> 0. Assert rst_i mid-MC_BUSY -> outputs 0 and busy_o=0 immediately.
